// File: rtl/decoder_pkg.sv
// Shared decoder definitions: default datapath width and requester IDs.
package decoder_pkg;

   localparam int unsigned DATA_W_DEFAULT = 23;

   localparam logic REQ_SYN = 1'b0;
   localparam logic REQ_COR = 1'b1;

endpackage : decoder_pkg

// File: rtl/large_xor.sv
// Combinational bitwise XOR used by the decoder for syndrome / error-pattern correction.
module large_xor #(
   parameter int unsigned WIDTH = 23
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_a ^ i_b;

endmodule : large_xor

// File: rtl/xor_req_arbiter.sv
// Round-robin share of one XOR datapath between the syndrome and correction stages,
// with a one-entry registered result stage and per-requester service counters.
module xor_req_arbiter
   import decoder_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   output logic              req1_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_id,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  cnt0,
   output logic [CNT_W-1:0]  cnt1
);

   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_id;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_cnt0;
   logic [CNT_W-1:0]  r_cnt1;

   logic              w_can_accept;
   logic              w_grant0;
   logic              w_grant1;
   logic              w_acc0;
   logic              w_acc1;
   logic              w_sel;
   logic [DATA_W-1:0] w_op_a;
   logic [DATA_W-1:0] w_op_b;
   logic [DATA_W-1:0] w_xor;

   // A full result slot can still take a new request when it drains this cycle.
   assign w_can_accept = !r_out_valid | out_ready;

   // Under contention the requester that did not win last time is granted.
   assign w_grant0 = req0_valid & (!req1_valid | (r_last_grant == REQ_COR));
   assign w_grant1 = req1_valid & (!req0_valid | (r_last_grant == REQ_SYN));

   assign req0_ready = w_grant0 & w_can_accept;
   assign req1_ready = w_grant1 & w_can_accept;

   assign w_acc0 = req0_valid & req0_ready;
   assign w_acc1 = req1_valid & req1_ready;

   assign w_sel  = w_grant1 ? REQ_COR : REQ_SYN;
   assign w_op_a = w_grant1 ? req1_a : req0_a;
   assign w_op_b = w_grant1 ? req1_b : req0_b;

   large_xor #(
      .WIDTH (DATA_W)
   ) u_large_xor (
      .i_a (w_op_a),
      .i_b (w_op_b),
      .o_y (w_xor)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_id     <= REQ_SYN;
         r_last_grant <= REQ_COR;
         r_cnt0       <= '0;
         r_cnt1       <= '0;
      end else if (w_acc0 | w_acc1) begin
         r_out_valid  <= 1'b1;
         r_out_data   <= w_xor;
         r_out_id     <= w_sel;
         r_last_grant <= w_sel;
         if (w_acc0) r_cnt0 <= r_cnt0 + 1'b1;
         if (w_acc1) r_cnt1 <= r_cnt1 + 1'b1;
      end else if (out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;
   assign cnt0      = r_cnt0;
   assign cnt1      = r_cnt1;

endmodule : xor_req_arbiter

// File: tb/tb_xor_req_arbiter.sv
// Directed self-checking bench for xor_req_arbiter.
module tb_xor_req_arbiter;

   localparam int unsigned DW = 23;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic          req0_ready, req1_ready, out_valid, out_id;
   logic [DW-1:0] out_data;
   logic [CW-1:0] cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   localparam logic [DW-1:0] R0A = 23'h123456, R0B = 23'h00FF00, R0X = 23'h12CB56;
   localparam logic [DW-1:0] R1A = 23'h7AAAAA, R1B = 23'h555555, R1X = 23'h2FFFFF;
   localparam logic [DW-1:0] NEWA = 23'h0F0F0F, NEWB = 23'h000FFF, NEWX = 23'h0F00F0;

   xor_req_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
      .cnt0(cnt0), .cnt1(cnt1)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({out_valid, req0_ready, req1_ready} !== 3'b000 || cnt0 !== '0 || cnt1 !== '0) begin
            errors++;
            $display("FAIL reset_idle cyc%0d: valid=%b rdy0=%b rdy1=%b cnt0=%0d cnt1=%0d, want all 0",
                     i, out_valid, req0_ready, req1_ready, cnt0, cnt1);
         end
         tick();
      end
      req1_valid = 1'b1; req1_a = R1A; req1_b = R1B;
      #1;
      checks++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_req1_ready: rdy0=%b rdy1=%b, want 0 1", req0_ready, req1_ready);
      end
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_a = 23'h7FFFFF; req0_b = 23'h000F0F; out_ready = 1'b1;
      tick();
      req0_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 23'h7FF0F0 || out_id !== 1'b0 || cnt0 !== 8'd1) begin
         errors++;
         $display("FAIL single: valid=%b data=%h id=%b cnt0=%0d, want 1 7ff0f0 0 1",
                  out_valid, out_data, out_id, cnt0);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 23'h7FF0F0) begin
         errors++;
         $display("FAIL single_drain: valid=%b data=%h, want 0 7ff0f0", out_valid, out_data);
      end
   endtask

   task automatic test_contention();
      do_reset();
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = R0A; req0_b = R0B;
      req1_valid = 1'b1; req1_a = R1A; req1_b = R1B;
      for (int i = 0; i < 6; i++) begin
         #1;
         checks++;
         if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL contention_ready cyc%0d: rdy0=%b rdy1=%b, want %b %b",
                     i, req0_ready, req1_ready, i % 2 == 0, i % 2 == 1);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_id !== logic'(i % 2) || out_data !== ((i % 2 == 0) ? R0X : R1X)) begin
            errors++;
            $display("FAIL contention_out cyc%0d: valid=%b id=%b data=%h, want 1 %0d %h",
                     i, out_valid, out_id, out_data, i % 2, (i % 2 == 0) ? R0X : R1X);
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (cnt0 !== 8'd3 || cnt1 !== 8'd3) begin
         errors++;
         $display("FAIL contention_cnt: cnt0=%0d cnt1=%0d, want 3 3", cnt0, cnt1);
      end
   endtask

   task automatic test_backpressure();
      // Result slot holds id1/R1X from the contention run; stall it with req0 waiting.
      out_ready = 1'b0;
      req0_valid = 1'b1; req0_a = NEWA; req0_b = NEWB;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready cyc%0d: rdy0=%b rdy1=%b, want 0 0", i, req0_ready, req1_ready);
         end
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_id !== 1'b1 || out_data !== R1X || cnt0 !== 8'd3 || cnt1 !== 8'd3) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: valid=%b id=%b data=%h cnt0=%0d cnt1=%0d, want 1 1 %h 3 3",
                     i, out_valid, out_id, out_data, cnt0, cnt1, R1X);
         end
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1) begin
         errors++;
         $display("FAIL unstall_ready: rdy0=%b, want 1", req0_ready);
      end
      tick();
      req0_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== NEWX || cnt0 !== 8'd4) begin
         errors++;
         $display("FAIL unstall_out: valid=%b id=%b data=%h cnt0=%0d, want 1 0 %h 4",
                  out_valid, out_id, out_data, cnt0, NEWX);
      end
   endtask

   task automatic test_wrap();
      out_ready = 1'b1;
      req1_valid = 1'b1; req1_a = R1A; req1_b = R1B;
      repeat (253) tick();
      checks++;
      if (cnt1 !== 8'd0) begin
         errors++;
         $display("FAIL wrap_zero: cnt1=%0d, want 0", cnt1);
      end
      repeat (3) tick();
      checks++;
      if (cnt1 !== 8'd3 || cnt0 !== 8'd4) begin
         errors++;
         $display("FAIL wrap_after: cnt1=%0d cnt0=%0d, want 3 4", cnt1, cnt0);
      end
   endtask

   task automatic test_async_reset();
      req1_valid = 1'b0; out_ready = 1'b0;
      tick();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: valid=%b, want 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || cnt0 !== '0 || cnt1 !== '0) begin
         errors++;
         $display("FAIL areset_now: valid=%b data=%h cnt0=%0d cnt1=%0d, want 0 0 0 0",
                  out_valid, out_data, cnt0, cnt1);
      end
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      req0_valid = 1'b1; req0_a = R0A; req0_b = R0B;
      req1_valid = 1'b1; req1_a = R1A; req1_b = R1B;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL areset_grant: rdy0=%b rdy1=%b, want 1 0", req0_ready, req1_ready);
      end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== R0X || cnt0 !== 8'd1) begin
         errors++;
         $display("FAIL areset_first: valid=%b id=%b data=%h cnt0=%0d, want 1 0 %h 1",
                  out_valid, out_id, out_data, cnt0, R0X);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_xor_req_arbiter
